udp_payload_commit_buf: RTL

//  Store-and-forward buffer directly downstream of udp_parser. Buffers UDP payload bytes per datagram.

---
 rtl/udp_buf_pkg.sv | 15 +
 rtl/udp_payload_commit_buf_if.sv | 24 ++
 rtl/udp_len_fifo.sv | 41 ++++
 rtl/udp_payload_commit_buf.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/udp_buf_pkg.sv
// Shared types and default sizing for the UDP payload commit buffer.
package udp_buf_pkg;

  localparam int unsigned LenWDef       = 11;
  localparam int unsigned MaxPayloadDef = 1472;

  typedef logic [LenWDef-1:0] len_t;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StOvf
  } wr_state_t;

endpackage

// File: rtl/udp_payload_commit_buf_if.sv
// Payload input stream from udp_parser plus the AXI-Stream style output of the commit buffer.
interface udp_payload_commit_buf_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_eof;
  logic       in_err;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;

  // The buffer itself is the slave; parser/consumer side is the master.
  modport slave (
    input  in_data, in_valid, in_eof, in_err, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output in_data, in_valid, in_eof, in_err, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/udp_len_fifo.sv
// Synchronous show-ahead FIFO holding committed datagram lengths (Depth must be a power of 2, >= 2).
module udp_len_fifo
  import udp_buf_pkg::*;
#(
  parameter int unsigned Depth  = 8,
  parameter type         data_t = len_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  data_t         mem_q [Depth];
  logic [PtrW:0] wp_q, rp_q;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[PtrW] != rp_q[PtrW]) && (wp_q[PtrW-1:0] == rp_q[PtrW-1:0]);
  assign data_o  = mem_q[rp_q[PtrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i && !full_o) wp_q <= wp_q + 1'b1;
      if (pop_i && !empty_o) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wp_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/udp_payload_commit_buf.sv
// Store-and-forward UDP payload buffer: releases a datagram only after a clean eof.
// Optional statistics counters are enabled with `define UDP_BUF_STATS_EN.
module udp_payload_commit_buf
  import udp_buf_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned MAX_FRAMES  = 8,
  parameter int unsigned MAX_PAYLOAD = MaxPayloadDef,
  parameter int unsigned LEN_W       = LenWDef
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  udp_payload_commit_buf_if.slave  bus_io,
  output logic                     frame_commit_o,
  output logic                     frame_drop_o
`ifdef UDP_BUF_STATS_EN
  ,
  output logic [15:0]              drop_cnt_o,
  output logic [15:0]              commit_cnt_o
`endif
);

  localparam int unsigned PtrW  = ADDR_W + 1;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [LEN_W-1:0] blen_t;

  logic [7:0] ram_q [Depth];
  logic [7:0] tdata_q;

  wr_state_t state_q, state_d;
  ptr_t      wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  blen_t     len_q, len_d, out_cnt_q, out_cnt_d;
  logic      commit_q, commit_d, drop_q, drop_d, tvalid_q, tvalid_d;

  ptr_t  used, fe_ptr;
  blen_t len_cur, len_new, head_len;
  logic  ram_full, has_byte, ovf_hit, byte_ok, in_frame, wr_en, push, pop;
  logic  fifo_full, fifo_empty, hs, last, rd_en;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign ram_full = (used == ptr_t'(Depth));

  udp_len_fifo #(
    .Depth  (MAX_FRAMES),
    .data_t (blen_t)
  ) u_len_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (len_new),
    .pop_i   (pop),
    .data_o  (head_len),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Write FSM: a datagram is written speculatively past cm_ptr and either committed or rewound.
  always_comb begin
    len_cur  = (state_q == StIdle) ? '0 : len_q;
    has_byte = bus_io.in_valid && (state_q != StOvf);
    ovf_hit  = has_byte && (ram_full || (32'(len_cur) >= MAX_PAYLOAD));
    byte_ok  = has_byte && !ovf_hit;
    len_new  = len_cur + blen_t'(byte_ok);
    in_frame = (state_q != StIdle) || bus_io.in_valid;

    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    wr_en    = 1'b0;
    push     = 1'b0;
    commit_d = 1'b0;
    drop_d   = 1'b0;

    if (bus_io.in_err) begin
      if (in_frame) begin
        state_d  = StIdle;
        wr_ptr_d = cm_ptr_q;
        drop_d   = 1'b1;
      end
    end else if (bus_io.in_eof) begin
      if (in_frame) begin
        state_d = StIdle;
        if ((state_q == StOvf) || ovf_hit || fifo_full) begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
        end else begin
          wr_en    = byte_ok;
          wr_ptr_d = wr_ptr_q + ptr_t'(byte_ok);
          cm_ptr_d = wr_ptr_d;
          push     = 1'b1;
          commit_d = 1'b1;
        end
      end
    end else if (ovf_hit) begin
      state_d = StOvf;
    end else if (byte_ok) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
      len_d    = len_new;
      state_d  = StRecv;
    end
  end

  // Read side: fe_ptr is the next byte to fetch, one ahead of rd_ptr while the output holds a byte.
  always_comb begin
    hs        = tvalid_q && bus_io.m_tready;
    last      = tvalid_q && (out_cnt_q + blen_t'(1) == head_len);
    fe_ptr    = rd_ptr_q + ptr_t'(tvalid_q);
    rd_en     = (fe_ptr != cm_ptr_q) && (!tvalid_q || bus_io.m_tready);
    rd_ptr_d  = rd_ptr_q + ptr_t'(hs);
    pop       = hs && last;
    tvalid_d  = rd_en ? 1'b1 : (hs ? 1'b0 : tvalid_q);
    out_cnt_d = out_cnt_q;
    if (hs) out_cnt_d = last ? '0 : out_cnt_q + blen_t'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      commit_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_cnt_q <= out_cnt_d;
      tvalid_q  <= tvalid_d;
      commit_q  <= commit_d;
      drop_q    <= drop_d;
    end
  end

  // Payload RAM with registered read port feeding the output directly.
  always_ff @(posedge clk_i) begin
    if (wr_en) ram_q[wr_ptr_q[ADDR_W-1:0]] <= bus_io.in_data;
    if (rd_en) tdata_q <= ram_q[fe_ptr[ADDR_W-1:0]];
  end

  assign bus_io.m_tdata  = tdata_q;
  assign bus_io.m_tvalid = tvalid_q;
  assign bus_io.m_tlast  = last;
  assign frame_commit_o  = commit_q;
  assign frame_drop_o    = drop_q;

`ifdef UDP_BUF_STATS_EN
  logic [15:0] drop_cnt_q, commit_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (commit_q) commit_cnt_q <= commit_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o   = drop_cnt_q;
  assign commit_cnt_o = commit_cnt_q;
`endif

endmodule
